// File: rtl/confidence_pkg.sv
// Shared types and widths for the confidence accumulator.
// Holds the FSM encoding and counter sizing.
package confidence_pkg;

  localparam int CONF_W_DEF = 10;
  localparam int PIX_CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/confidence_accum_sat_counter.sv
// Width-parameterised up-counter with clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // clear wins over increment; hold once saturated
  always_ff @(posedge clk) begin
    if (reset || clr)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/confidence_accum.sv
// Counts template matches over one pixel window
// and strobes the final counts downstream.
module confidence_accum
  import confidence_pkg::*;
#(
  parameter int N_PIX  = 400,
  parameter int CONF_W = CONF_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              ABORT,
  input  logic              pix_valid,
  input  logic              pix_is_blk,
  input  logic              pix_is_wht,
  input  logic              tmpl_blk,
  output logic [CONF_W-1:0] confidence_BLK,
  output logic [CONF_W-1:0] confidence_WHT,
  output logic              WE,
  output logic              BUSY
);

  localparam logic [PIX_CNT_W-1:0] LAST =
    PIX_CNT_W'(N_PIX - 1);

  state_t               state;
  state_t               state_nx;
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic                 clr;
  logic                 acc;
  logic                 inc_blk;
  logic                 inc_wht;

  // next state and window control; abort beats the last pixel
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    acc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (START && !ABORT) begin
          clr      = 1'b1;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        if (ABORT) begin
          state_nx = IDLE;
        end else if (pix_valid) begin
          acc = 1'b1;
          if (pix_cnt == LAST)
            state_nx = WRITE;
        end
      end
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // pixels seen in the current window
  always_ff @(posedge CLK) begin
    if (RESET || clr)
      pix_cnt <= '0;
    else if (acc)
      pix_cnt <= pix_cnt + 1'b1;
  end

  assign inc_blk = acc & tmpl_blk
                 & pix_is_blk & ~pix_is_wht;
  assign inc_wht = acc & ~tmpl_blk
                 & pix_is_wht & ~pix_is_blk;

  sat_counter #(.W(CONF_W)) u_blk (
    .clk   (CLK),
    .reset (RESET),
    .clr   (clr),
    .inc   (inc_blk),
    .count (confidence_BLK)
  );

  sat_counter #(.W(CONF_W)) u_wht (
    .clk   (CLK),
    .reset (RESET),
    .clr   (clr),
    .inc   (inc_wht),
    .count (confidence_WHT)
  );

  assign WE   = (state == WRITE);
  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_confidence_accum.sv
// Randomised and directed bench for confidence_accum.
// Three instances share stimulus against a window-level model.
module tb_confidence_accum;

  logic CLK = 1'b0;
  logic RESET, START, ABORT, pix_valid;
  logic pix_is_blk, pix_is_wht, tmpl_blk;

  logic [9:0] b0, w0, b1, w1;
  logic [7:0] b2, w2;
  logic we0, we1, we2, bz0, bz1, bz2;

  always #5 CLK = ~CLK;

  confidence_accum #(.N_PIX(4), .CONF_W(10)) dut0 (
    .CLK(CLK), .RESET(RESET), .START(START),
    .ABORT(ABORT), .pix_valid(pix_valid),
    .pix_is_blk(pix_is_blk), .pix_is_wht(pix_is_wht),
    .tmpl_blk(tmpl_blk), .confidence_BLK(b0),
    .confidence_WHT(w0), .WE(we0), .BUSY(bz0));

  confidence_accum #(.N_PIX(400), .CONF_W(10)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(START),
    .ABORT(ABORT), .pix_valid(pix_valid),
    .pix_is_blk(pix_is_blk), .pix_is_wht(pix_is_wht),
    .tmpl_blk(tmpl_blk), .confidence_BLK(b1),
    .confidence_WHT(w1), .WE(we1), .BUSY(bz1));

  confidence_accum #(.N_PIX(1023), .CONF_W(8)) dut2 (
    .CLK(CLK), .RESET(RESET), .START(START),
    .ABORT(ABORT), .pix_valid(pix_valid),
    .pix_is_blk(pix_is_blk), .pix_is_wht(pix_is_wht),
    .tmpl_blk(tmpl_blk), .confidence_BLK(b2),
    .confidence_WHT(w2), .WE(we2), .BUSY(bz2));

  localparam int NP [3] = '{4, 400, 1023};
  localparam int MX [3] = '{1023, 1023, 255};

  bit act [3];
  bit wr  [3];
  int seen [3];
  int mb [3];
  int mw [3];

  int passed = 0;
  int total  = 0;
  int we0_cnt = 0;
  int we1_cnt = 0;

  // window-level reference: per instance, one window in flight
  always @(posedge CLK) begin
    for (int m = 0; m < 3; m++) begin
      if (RESET) begin
        act[m] = 0; wr[m] = 0;
        seen[m] = 0; mb[m] = 0; mw[m] = 0;
      end else if (wr[m]) begin
        wr[m] = 0;
      end else if (act[m]) begin
        if (ABORT) begin
          act[m] = 0;
        end else if (pix_valid) begin
          seen[m]++;
          if (tmpl_blk && pix_is_blk && !pix_is_wht)
            mb[m] = (mb[m] < MX[m]) ? mb[m] + 1 : mb[m];
          if (!tmpl_blk && pix_is_wht && !pix_is_blk)
            mw[m] = (mw[m] < MX[m]) ? mw[m] + 1 : mw[m];
          if (seen[m] == NP[m]) begin
            act[m] = 0; wr[m] = 1;
          end
        end
      end else if (START && !ABORT) begin
        act[m] = 1;
        seen[m] = 0; mb[m] = 0; mw[m] = 0;
      end
    end
  end

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic check_all();
    chk("d0_blk", int'(b0), mb[0]);
    chk("d0_wht", int'(w0), mw[0]);
    chk("d0_we",  int'(we0), int'(wr[0]));
    chk("d0_bsy", int'(bz0), int'(act[0] | wr[0]));
    chk("d1_blk", int'(b1), mb[1]);
    chk("d1_wht", int'(w1), mw[1]);
    chk("d1_we",  int'(we1), int'(wr[1]));
    chk("d1_bsy", int'(bz1), int'(act[1] | wr[1]));
    chk("d2_blk", int'(b2), mb[2]);
    chk("d2_wht", int'(w2), mw[2]);
    chk("d2_we",  int'(we2), int'(wr[2]));
    chk("d2_bsy", int'(bz2), int'(act[2] | wr[2]));
    if (we0) we0_cnt++;
    if (we1) we1_cnt++;
  endtask

  task automatic cyc(input logic st, input logic ab,
                     input logic pv, input logic pb,
                     input logic pw, input logic tb,
                     input logic rs);
    START = st; ABORT = ab; pix_valid = pv;
    pix_is_blk = pb; pix_is_wht = pw;
    tmpl_blk = tb; RESET = rs;
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_bsy0", int'(bz0), 0);
    chk("rst_blk2", int'(b2), 0);

    // four black matches
    we0_cnt = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 1, 0, 1, 0);
    chk("r031_we", int'(we0), 1);
    chk("r031_blk", int'(b0), 4);
    chk("r031_wht", int'(w0), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("r031_we_off", int'(we0), 0);
    chk("r031_hold", int'(b0), 4);
    chk("r031_once", we0_cnt, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // abort together with the final pixel
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0, 1, 0);
    chk("r034_we", int'(we0), 0);
    chk("r034_bsy", int'(bz0), 0);
    chk("r034_frozen", int'(b0), 3);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("r034_we2", int'(we0), 0);

    // reset mid-window, then four white matches
    we0_cnt = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 1, 0, 0);
    chk("r035_we", int'(we0), 1);
    chk("r035_wht", int'(w0), 4);
    chk("r035_blk", int'(b0), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("r035_once", we0_cnt, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // start ignored mid-window; both-set pixels count only
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 1, 0);
    cyc(1, 0, 1, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 1, 0);
    chk("r036_we", int'(we0), 1);
    chk("r036_blk", int'(b0), 2);
    chk("r036_wht", int'(w0), 0);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // 400-pixel window, alternating template, 50% valid
    we1_cnt = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      logic t;
      t = ((i / 2) % 2) == 1;
      cyc(0, 0, logic'(i % 2), t, !t, t, 0);
    end
    chk("r032_we", int'(we1), 1);
    chk("r032_blk", int'(b1), 200);
    chk("r032_wht", int'(w1), 200);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("r032_once", we1_cnt, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // saturation with 8-bit counts over 1023 pixels
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (1023) cyc(0, 0, 1, 1, 0, 1, 0);
    chk("r033_we", int'(we2), 1);
    chk("r033_sat", int'(b2), 255);
    chk("r033_wht", int'(w2), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 19) == 0,
          $urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 7,
          1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 499) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/confidence_accum.md
CONFIDENCE_ACCUM -- requirements
Module: confidence_accum

Interface
REQ-001 Parameter N_PIX, default 400, SHALL be the number of valid pixels per window (20x20 template); legal range 1..1023.
REQ-002 Parameter CONF_W, default 10, SHALL be the confidence output width.
REQ-003 CLK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RESET  in  1  SHALL be the synchronous, active-high reset.
REQ-005 START  in  1  SHALL be the request to begin a new window (level-sampled, single-cycle pulse expected).
REQ-006 ABORT  in  1  SHALL cancel the current window with no write.
REQ-007 pix_valid  in  1  SHALL qualify pix_is_blk, pix_is_wht and tmpl_blk in the same cycle.
REQ-008 pix_is_blk / pix_is_wht  in  1 each  SHALL be the classified pixel (both 0 allowed; both 1 SHALL count as neither).
REQ-009 tmpl_blk  in  1  SHALL be the template bit: 1 = black expected, 0 = white expected.
REQ-010 confidence_BLK / confidence_WHT  out  CONF_W each  SHALL be the black-match and white-match counts.
REQ-011 WE  out  1  SHALL be a one-cycle write strobe to the downstream confidence register.
REQ-012 BUSY  out  1  SHALL be high in ACCUM and WRITE.

Function
REQ-013 FSM states SHALL be IDLE, ACCUM, WRITE.
REQ-014 In IDLE with START=1 and ABORT=0: next state ACCUM; pixel counter, confidence_BLK and confidence_WHT cleared to 0 on that edge.
REQ-015 In ACCUM, each cycle with pix_valid=1 SHALL increment the pixel counter by 1.
REQ-016 Black match (tmpl_blk=1, pix_is_blk=1, pix_is_wht=0) SHALL increment confidence_BLK; white match (tmpl_blk=0, pix_is_wht=1, pix_is_blk=0) SHALL increment confidence_WHT; at most one increments per pixel.
REQ-017 Both confidence counts SHALL saturate at 2^CONF_W-1 and never wrap.
REQ-018 The valid pixel that brings the count to N_PIX SHALL be accumulated and move the FSM to WRITE on that edge.
REQ-019 In WRITE, WE SHALL be 1 for exactly one cycle with final counts on the outputs; the next state SHALL be IDLE.
REQ-020 Counts SHALL hold their final values in IDLE until the next accepted START.
REQ-021 pix_valid SHALL be ignored in IDLE and WRITE.
REQ-022 START SHALL be ignored in ACCUM and WRITE.
REQ-023 ABORT in ACCUM SHALL return to IDLE with no WE pulse, counts frozen; ABORT in WRITE SHALL have no effect; ABORT in IDLE SHALL block START.
REQ-024 ABORT coincident with the final pixel SHALL take priority: no WRITE, no WE.
REQ-025 Latency from the final valid pixel edge to WE high SHALL be exactly 1 cycle.

Reset
REQ-026 RESET=1 SHALL force state IDLE, pixel counter 0, confidence_BLK=0, confidence_WHT=0, WE=0, BUSY=0 on the next edge, overriding all other inputs.
REQ-027 RESET asserted in ACCUM or WRITE SHALL discard the window with no WE pulse.

Structure
REQ-028 CONF_W default, the state enum (IDLE/ACCUM/WRITE) and the pixel-counter width SHALL live in shared package confidence_pkg.
REQ-029 A sub-module sat_counter (clear, increment enable, saturating, width-parameterised) SHALL be instanced twice, once per colour.
REQ-030 All outputs SHALL be registered; WE SHALL be decoded from the registered state.

Verification
REQ-031 N_PIX=4; START, 4 valid pixels all black matches -> WE one cycle, confidence_BLK=4, confidence_WHT=0, one cycle after 4th pixel.
REQ-032 N_PIX=400; alternating template and matching pixels with pix_valid 50% duty -> confidence_BLK=200, confidence_WHT=200, WE exactly once.
REQ-033 N_PIX=1023, CONF_W=8, all black matches -> confidence_BLK=255 (saturated), no wrap.
REQ-034 N_PIX=4; ABORT with 4th valid pixel -> no WE, state IDLE, BUSY=0.
REQ-035 N_PIX=4; RESET after 2 pixels, then START + 4 white matches -> single WE, confidence_WHT=4, confidence_BLK=0.
REQ-036 START pulsed mid-ACCUM and both pix_is_blk=pix_is_wht=1 pixels -> window not restarted, those pixels count toward N_PIX but add no match.
